// File: rtl/param_sorter.sv
// param_sorter: in-place selection sorter over a DEPTH x WIDTH simple-dual-port
// RAM with synchronous read/write. While idle the host owns the RAM through one
// address port; `start` sorts ascending or descending (per `desc`) and returns
// to idle with a one-cycle `done` pulse.
// Optional build macro SORTER_SWAPCNT_EN adds the `nswaps` swap-count output.
module param_sorter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             desc,
    input  logic             wr,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] datain,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] dataout
`ifdef SORTER_SWAPCNT_EN
    ,
    output logic [AW-1:0]    nswaps
`endif
);

    localparam logic [AW-1:0] LAST_J = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_I = AW'(DEPTH - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FIRST, S_SCAN, S_SWAP, S_SWAP2
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0]    i_q, i_d;
    logic [AW-1:0]    j_q, j_d;
    logic [AW-1:0]    jm_q, jm_d;
    logic [WIDTH-1:0] a_q, a_d;     // original mem[i], written to mem[jm] on a swap
    logic [WIDTH-1:0] m_q, m_d;     // best value found so far in this pass
    logic             ord_q, ord_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] dataout_q;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [AW-1:0]    mem_raddr;

    logic better, last_j, last_i, swap_needed;

    // Strict compare so the earliest of several equal candidates wins.
    always_comb begin
        better      = ord_q ? (dataout_q > m_q) : (dataout_q < m_q);
        last_j      = (j_q == LAST_J);
        last_i      = (i_q == LAST_I);
        swap_needed = (jm_q != i_q);
    end

    // RAM storage and registered read port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        dataout_q <= mem[mem_raddr];
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; the completion check is folded into SWAP/SWAP2.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = S_FIRST;
            S_FIRST: state_d = S_SCAN;
            S_SCAN:  if (last_j) state_d = S_SWAP;
            S_SWAP: begin
                if (swap_needed) state_d = S_SWAP2;
                else             state_d = last_i ? S_IDLE : S_LOAD;
            end
            S_SWAP2: state_d = last_i ? S_IDLE : S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // RAM port control and status outputs.
    always_comb begin
        ready     = (state_q == S_IDLE);
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = datain;
        mem_raddr = addr;
        case (state_q)
            S_IDLE:  mem_we = wr;
            S_LOAD:  mem_raddr = i_q;
            S_FIRST: mem_raddr = i_q + 1'b1;
            S_SCAN:  mem_raddr = j_q + 1'b1;
            S_SWAP: begin
                mem_we    = swap_needed;
                mem_waddr = jm_q;
                mem_wdata = a_q;
            end
            S_SWAP2: begin
                mem_we    = 1'b1;
                mem_waddr = i_q;
                mem_wdata = m_q;
            end
            default: ;
        endcase
    end

    // Datapath register updates for the scan/swap sequence.
    always_comb begin
        i_d    = i_q;
        j_d    = j_q;
        jm_d   = jm_q;
        a_d    = a_q;
        m_d    = m_q;
        ord_d  = ord_q;
        done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ord_d = desc;
                    i_d   = '0;
                end
            end
            S_FIRST: begin
                a_d  = dataout_q;
                m_d  = dataout_q;
                jm_d = i_q;
                j_d  = i_q + 1'b1;
            end
            S_SCAN: begin
                if (better) begin
                    m_d  = dataout_q;
                    jm_d = j_q;
                end
                if (!last_j) j_d = j_q + 1'b1;
            end
            S_SWAP: begin
                if (!swap_needed) begin
                    if (last_i) done_d = 1'b1;
                    else        i_d    = i_q + 1'b1;
                end
            end
            S_SWAP2: begin
                if (last_i) done_d = 1'b1;
                else        i_d    = i_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            i_q    <= '0;
            j_q    <= '0;
            jm_q   <= '0;
            a_q    <= '0;
            m_q    <= '0;
            ord_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            i_q    <= i_d;
            j_q    <= j_d;
            jm_q   <= jm_d;
            a_q    <= a_d;
            m_q    <= m_d;
            ord_q  <= ord_d;
            done_q <= done_d;
        end
    end

    assign done    = done_q;
    assign dataout = dataout_q;

`ifdef SORTER_SWAPCNT_EN
    logic [AW-1:0] nswaps_q, nswaps_d;

    // Swap counter: cleared on an accepted start, bumped once per SWAP2.
    always_comb begin
        nswaps_d = nswaps_q;
        if (state_q == S_IDLE && start) nswaps_d = '0;
        else if (state_q == S_SWAP2)    nswaps_d = nswaps_q + 1'b1;
    end

    // Swap counter register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) nswaps_q <= '0;
        else       nswaps_q <= nswaps_d;
    end

    assign nswaps = nswaps_q;
`endif

endmodule

// File: tb/tb_param_sorter.sv
// Directed bench for param_sorter: an 8x8 instance for the hand-computed
// vectors and a 16x16 instance checked against a reference selection sort.
module tb_param_sorter;

    logic        clk, nrst;
    logic        st8, ds8, wr8;
    logic [2:0]  ad8;
    logic [7:0]  di8;
    logic        rdy8, dn8;
    logic [7:0]  do8;
    logic        st16, ds16, wr16;
    logic [3:0]  ad16;
    logic [15:0] di16;
    logic        rdy16, dn16;
    logic [15:0] do16;
`ifdef SORTER_SWAPCNT_EN
    logic [2:0]  ns8;
    logic [3:0]  ns16;
`endif

    int npass = 0;
    int ntotal = 0;
    logic [15:0] ref16 [16];

    param_sorter #(.WIDTH(8), .DEPTH(8)) u8 (
        .clk(clk), .nrst(nrst), .start(st8), .desc(ds8), .wr(wr8),
        .addr(ad8), .datain(di8), .ready(rdy8), .done(dn8), .dataout(do8)
`ifdef SORTER_SWAPCNT_EN
        , .nswaps(ns8)
`endif
    );

    param_sorter #(.WIDTH(16), .DEPTH(16)) u16 (
        .clk(clk), .nrst(nrst), .start(st16), .desc(ds16), .wr(wr16),
        .addr(ad16), .datain(di16), .ready(rdy16), .done(dn16), .dataout(do16)
`ifdef SORTER_SWAPCNT_EN
        , .nswaps(ns16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit rdy(input int w);
        return (w == 0) ? rdy8 : rdy16;
    endfunction

    function automatic bit dn(input int w);
        return (w == 0) ? dn8 : dn16;
    endfunction

    task automatic wr_word(input int w, input int a, input logic [15:0] v);
        if (w == 0) begin wr8 = 1'b1; ad8 = 3'(a); di8 = v[7:0]; end
        else begin wr16 = 1'b1; ad16 = 4'(a); di16 = v; end
        tick;
        wr8 = 1'b0;
        wr16 = 1'b0;
    endtask

    // Word k of the packed vector sits at v[8k +: 8] (address 0 in the LSBs).
    task automatic load8(input logic [63:0] v);
        for (int k = 0; k < 8; k++) wr_word(0, k, {8'h00, v[8*k +: 8]});
    endtask

    task automatic readback8(input string tag, input logic [63:0] exp);
        for (int k = 0; k < 8; k++) begin
            ad8 = 3'(k);
            tick;
            chk($sformatf("%s[%0d]", tag, k), {24'h0, do8}, {24'h0, exp[8*k +: 8]});
        end
    endtask

    task automatic readback16(input string tag);
        for (int k = 0; k < 16; k++) begin
            ad16 = 4'(k);
            tick;
            chk($sformatf("%s[%0d]", tag, k), {16'h0, do16}, {16'h0, ref16[k]});
        end
    endtask

    // Start a sort, count ready-low cycles and done pulses; optionally try to
    // disturb the DUT with a write and a second start on busy cycle `inj`.
    // Leaves the bench one cycle past the first ready cycle with first = mem[0].
    task automatic run_sort(input int w, input bit d, input int inj,
                            output int busy, output int dones, output int first);
        if (w == 0) begin st8 = 1'b1; ds8 = d; end
        else begin st16 = 1'b1; ds16 = d; end
        tick;
        st8 = 1'b0; st16 = 1'b0; wr8 = 1'b0; wr16 = 1'b0;
        busy = 0;
        dones = 0;
        while (!rdy(w) && busy < 2000) begin
            busy++;
            if (inj != 0 && busy == inj) begin
                wr8 = 1'b1; ad8 = 3'd0; di8 = 8'hAA; st8 = 1'b1; ds8 = ~d;
            end
            tick;
            st8 = 1'b0;
            wr8 = 1'b0;
            if (dn(w)) dones++;
        end
        ad8 = 3'd0;
        ad16 = 4'd0;
        tick;
        if (dn(w)) dones++;
        first = (w == 0) ? int'(do8) : int'(do16);
    endtask

    // Reference selection sort over ref16 with the same tie rule (first wins).
    task automatic model16(input bit d, output int sw);
        logic [15:0] t;
        int best;
        sw = 0;
        for (int i = 0; i < 15; i++) begin
            best = i;
            for (int j = i + 1; j < 16; j++)
                if (d ? (ref16[j] > ref16[best]) : (ref16[j] < ref16[best])) best = j;
            if (best != i) begin
                t = ref16[i]; ref16[i] = ref16[best]; ref16[best] = t;
                sw++;
            end
        end
    endtask

    initial begin
        int busy, dones, first, sw;
        logic [15:0] init16 [16];
        init16 = '{16'h1234, 16'hFFFF, 16'h0000, 16'h8000, 16'h00FF, 16'hFFFF,
                   16'h0001, 16'h7FFF, 16'hABCD, 16'h0000, 16'h5555, 16'hAAAA,
                   16'h0F0F, 16'hF0F0, 16'h4321, 16'h8001};

        nrst = 1'b0;
        st8 = 0; ds8 = 0; wr8 = 0; ad8 = 0; di8 = 0;
        st16 = 0; ds16 = 0; wr16 = 0; ad16 = 0; di16 = 0;
        tick;
        tick;
        chk("rst_ready8", {31'h0, rdy8}, 32'd1);
        chk("rst_done8", {31'h0, dn8}, 32'd0);
        chk("rst_ready16", {31'h0, rdy16}, 32'd1);
        chk("rst_done16", {31'h0, dn16}, 32'd0);
`ifdef SORTER_SWAPCNT_EN
        chk("rst_nswaps8", {29'h0, ns8}, 32'd0);
`endif
        nrst = 1'b1;
        tick;

        // 8..1 ascending: 4 swaps, 53 busy cycles.
        load8(64'h0102030405060708);
        run_sort(0, 1'b0, 0, busy, dones, first);
        chk("t1_busy", busy, 53);
        chk("t1_dones", dones, 1);
        chk("t1_first_read", first, 1);
        readback8("t1_data", 64'h0807060504030201);
`ifdef SORTER_SWAPCNT_EN
        chk("t1_nswaps", {29'h0, ns8}, 32'd4);
`endif

        // Already ascending: no swaps, 49 cycles, then descending.
        run_sort(0, 1'b0, 0, busy, dones, first);
        chk("t2_busy_asc", busy, 49);
        readback8("t2_data_asc", 64'h0807060504030201);
`ifdef SORTER_SWAPCNT_EN
        chk("t2_nswaps_asc", {29'h0, ns8}, 32'd0);
`endif
        run_sort(0, 1'b1, 0, busy, dones, first);
        chk("t2_busy_desc", busy, 53);
        readback8("t2_data_desc", 64'h0102030405060708);
`ifdef SORTER_SWAPCNT_EN
        chk("t2_nswaps_desc", {29'h0, ns8}, 32'd4);
`endif

        // Duplicates {3,1,3,1,2,2,0,0}: 4 swaps; done exactly one cycle.
        load8(64'h0000020201030103);
        run_sort(0, 1'b0, 0, busy, dones, first);
        chk("t3_busy", busy, 53);
        chk("t3_dones", dones, 1);
        readback8("t3_data", 64'h0303020201010000);

        // Disturb while busy: {5,3,7,1,8,2,6,4} -> 1..8, 6 swaps, 55 cycles.
        load8(64'h0406020801070305);
        run_sort(0, 1'b0, 5, busy, dones, first);
        chk("t4_busy", busy, 55);
        chk("t4_dones", dones, 1);
        readback8("t4_data", 64'h0807060504030201);
`ifdef SORTER_SWAPCNT_EN
        chk("t4_nswaps", {29'h0, ns8}, 32'd6);
`endif

        // Write and start together: the sort sees {1..7,0} -> 0..7, 7 swaps.
        load8(64'h0807060504030201);
        wr8 = 1'b1; ad8 = 3'd7; di8 = 8'h00;
        run_sort(0, 1'b0, 0, busy, dones, first);
        chk("t5_busy", busy, 56);
        readback8("t5_data", 64'h0706050403020100);

        // Reset 10 cycles into a sort: idle at once, no done, then a clean sort.
        load8(64'h0102030405060708);
        st8 = 1'b1; ds8 = 1'b0;
        tick;
        st8 = 1'b0;
        dones = 0;
        for (int c = 0; c < 9; c++) begin
            tick;
            if (dn8) dones++;
        end
        chk("t6_busy_before_rst", {31'h0, rdy8}, 32'd0);
        nrst = 1'b0;
        #1;
        chk("t6_ready_in_rst", {31'h0, rdy8}, 32'd1);
        chk("t6_done_in_rst", {31'h0, dn8}, 32'd0);
`ifdef SORTER_SWAPCNT_EN
        chk("t6_nswaps_in_rst", {29'h0, ns8}, 32'd0);
`endif
        tick;
        nrst = 1'b1;
        tick;
        if (dn8) dones++;
        chk("t6_no_done", dones, 0);
        load8(64'h0102030405060708);
        run_sort(0, 1'b0, 0, busy, dones, first);
        chk("t6_busy_after", busy, 53);
        readback8("t6_data", 64'h0807060504030201);

        // 16x16 with extreme values, ascending then descending.
        for (int k = 0; k < 16; k++) begin
            wr_word(1, k, init16[k]);
            ref16[k] = init16[k];
        end
        model16(1'b0, sw);
        run_sort(1, 1'b0, 0, busy, dones, first);
        chk("t7_busy_asc", busy, 165 + sw);
        chk("t7_dones_asc", dones, 1);
        readback16("t7_data_asc");
`ifdef SORTER_SWAPCNT_EN
        chk("t7_nswaps_asc", {28'h0, ns16}, sw);
`endif
        model16(1'b1, sw);
        run_sort(1, 1'b1, 0, busy, dones, first);
        chk("t7_busy_desc", busy, 165 + sw);
        readback16("t7_data_desc");
`ifdef SORTER_SWAPCNT_EN
        chk("t7_nswaps_desc", {28'h0, ns16}, sw);
`endif

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/param_sorter.md
# param_sorter

Parametrised in-place selection sorter around a DEPTH×WIDTH simple-dual-port RAM with synchronous read and write. It is the next generation of the fixed 8×8 sorter. While idle, the host loads and reads the RAM through a single address port. On `start` the block sorts the RAM contents in place, ascending or descending, selected per run by `desc`. It then returns to idle with a one-cycle `done` pulse.

## Interface
- `WIDTH`, 8, data word width in bits; comparison is unsigned.
- `DEPTH`, 8, number of words; power of two, ≥2; `AW = $clog2(DEPTH)`.
- `clk`  in  1  clock, all logic on posedge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin sort; honoured only while `ready`=1.
- `desc`  in  1  sort order, sampled with `start`: 0 = ascending, 1 = descending.
- `wr`  in  1  host write enable; honoured only while `ready`=1.
- `addr`  in  AW  host read/write address.
- `datain`  in  WIDTH  host write data.
- `ready`  out  1  idle, host owns the RAM.
- `done`  out  1  one-cycle pulse at sort completion.
- `dataout`  out  WIDTH  registered RAM read data.
- `nswaps`  out  AW  swap count of the last sort; present only with `SORTER_SWAPCNT_EN`.

## Operation
- **Memory**
  - RAM has one read port and one write port; read data is registered.
  - RAM is not cleared by reset.
- **IDLE** (`ready`=1)
  - Read address = `addr`; `dataout` = mem[`addr`] one cycle later.
  - `wr`=1 writes `datain` to mem[`addr`] at the edge.
  - `start`=1 latches `desc` into `ord`, sets i←0, clears `nswaps`, and goes to LOAD.
  - If `wr` and `start` are high together, the write completes and the sort sees the new value.
- **LOAD**: read address = i → FIRST.
- **FIRST**
  - a←dataout (original mem[i]), m←dataout, jm←i, j←i+1.
  - Read address = i+1 → SCAN.
- **SCAN**: dataout = mem[j] each cycle.
  - better = ord ? dataout>m : dataout<m (strict, so the earliest equal element is kept).
  - If better: m←dataout, jm←j.
  - If j==DEPTH-1 → SWAP. Otherwise j←j+1 and read address = j+1.
- **SWAP**
  - If jm≠i: write mem[jm]←a → SWAP2.
  - Otherwise → completion check.
- **SWAP2**: write mem[i]←m; `nswaps`+1 → completion check.
- **Completion check**
  - If i==DEPTH-2 → IDLE, `done`=1 for one cycle.
  - Otherwise i←i+1 → LOAD.
- **While busy**
  - `wr`, `start`, `addr`, `datain` and `desc` are ignored.
  - `dataout` shows internal reads and has no host meaning.
- **Widths**: i, j and jm are AW bits. j never exceeds DEPTH-1, so no wrap.

## Timing
- **Reset values**: state IDLE; `ready`=1; `done`=0; `nswaps`=0. `dataout` is undefined until the first read.
- `ready` falls on the edge that samples `start`. It rises on the same edge that asserts `done`.
- Busy cycles (`ready`=0) = 3·(DEPTH-1) + DEPTH·(DEPTH-1)/2 + swaps; 49+swaps for DEPTH=8.
- The first host read after `done` returns sorted data: issue `addr` on the first `ready` cycle, and `dataout` is valid on the next.
- **Reset mid-sort**
  - Immediate return to IDLE; `done` is not pulsed.
  - RAM keeps its partially sorted contents; `nswaps` reads 0.
- Swap writes always precede the next LOAD read, so there is no read/write hazard.

## Configuration
- `SORTER_SWAPCNT_EN` defined:
  - `nswaps` port exists.
  - Cleared on accepted `start`; incremented once per SWAP2; holds after `done` until the next `start` or reset.
- Not defined:
  - Port and counter are absent.
  - Sort behaviour and timing are identical.

## Test plan
- DEPTH=8, WIDTH=8: load 8,7,…,1, `desc`=0, `start` -> `ready` low 53 cycles, `done` pulse, readback 1..8, `nswaps`=4.
- Load 1..8, ascending -> busy exactly 49 cycles, RAM unchanged, `nswaps`=0; then `desc`=1 -> readback 8..1, `nswaps`=4.
- Load {3,1,3,1,2,2,0,0}, ascending -> readback 0,0,1,1,2,2,3,3; `done` high exactly one cycle.
- During sort, assert `wr` to addr 0 with 0xAA and pulse `start` again -> no effect; single `done`; result matches the golden model.
- Assert `nrst` low 10 cycles after `start` -> `ready`=1 immediately, no `done`, `nswaps`=0; a new full sort then completes correctly.
- DEPTH=16, WIDTH=16: random data including 0xFFFF and 0x0000, both orders -> matches reference sort; busy = 165 + `nswaps` cycles.
